// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer
//   Stall, bubble, flush and forwarding control for a 3-stage F/X/W RISC-V pipeline.
//   Hazard detection is combinational. A small FSM (RUN / MEM_WAIT / FLUSH) covers the
//   multi-cycle events: data-memory wait, multi-cycle branch flush and the one-cycle
//   load-use re-detect block. The control outputs are Mealy (state + current inputs).
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_opcode_x/_w           opcodes of the instructions in X and W
//   i_rd_w, i_rs1_x, i_rs2_x register indices used for hazard and forward detection
//   i_branch_taken          X-stage redirect (qualified by a branch/jump opcode in X)
//   i_dmem_req/_ready       data-memory handshake
//   i_cnt_clr               synchronous clear of the stall counter
//   o_pc_hold, o_fx_we      PC hold and F/X register write enable
//   o_x_noop, o_flush       bubble injection into X, squash of F
//   o_fwd_a, o_fwd_b        forward W result to ALU operand A / B
//   o_mem_err               sticky memory-wait timeout flag
//   o_stall_cnt             saturating count of cycles with o_pc_hold=1
module pipeline_stall_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_opcode_x,
    input  logic [6:0]       i_opcode_w,
    input  logic [4:0]       i_rd_w,
    input  logic [4:0]       i_rs1_x,
    input  logic [4:0]       i_rs2_x,
    input  logic             i_branch_taken,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    input  logic             i_cnt_clr,
    output logic             o_pc_hold,
    output logic             o_fx_we,
    output logic             o_x_noop,
    output logic             o_flush,
    output logic             o_fwd_a,
    output logic             o_fwd_b,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_e;

    state_e           r_state;
    logic             r_lu_block;
    logic             r_pend_flush;
    logic [7:0]       r_wait_cnt;
    logic [2:0]       r_flush_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_mem_stall;
    logic       w_branch;
    logic       w_w_writes;
    logic       w_load_use;
    logic [7:0] w_wait_inc;
    logic       w_timeout;

    assign w_mem_stall = i_dmem_req & ~i_dmem_ready;
    // A redirect only counts when X actually holds a control-transfer instruction.
    assign w_branch    = i_branch_taken &
                         (i_opcode_x == OPC_BRANCH || i_opcode_x == OPC_JAL ||
                          i_opcode_x == OPC_JALR);
    assign w_w_writes  = (i_opcode_w == OPC_ARI_RTYPE) || (i_opcode_w == OPC_ARI_ITYPE) ||
                         (i_opcode_w == OPC_LUI) || (i_opcode_w == OPC_AUIPC) ||
                         (i_opcode_w == OPC_JAL) || (i_opcode_w == OPC_JALR);
    assign w_load_use  = (i_opcode_w == OPC_LOAD) && (i_rd_w != 5'd0) &&
                         ((i_rd_w == i_rs1_x) || (i_rd_w == i_rs2_x)) && !r_lu_block;
    assign w_wait_inc  = r_wait_cnt + 8'd1;
    assign w_timeout   = (w_wait_inc == WAIT_LIMIT);

    assign o_fwd_a     = (r_state == StRun) && (i_rd_w != 5'd0) && (i_rd_w == i_rs1_x) &&
                         w_w_writes;
    assign o_fwd_b     = (r_state == StRun) && (i_rd_w != 5'd0) && (i_rd_w == i_rs2_x) &&
                         w_w_writes;
    assign o_mem_err   = r_mem_err;
    assign o_stall_cnt = r_stall_cnt;

    always_comb begin
        o_pc_hold = 1'b0;
        o_fx_we   = 1'b1;
        o_x_noop  = 1'b0;
        o_flush   = 1'b0;
        unique case (r_state)
            StRun: begin
                if (w_mem_stall) begin
                    o_pc_hold = 1'b1;
                    o_fx_we   = 1'b0;
                end else if (w_load_use) begin
                    o_pc_hold = 1'b1;
                    o_fx_we   = 1'b0;
                    o_x_noop  = 1'b1;
                end else if (w_branch) begin
                    o_flush   = 1'b1;
                end
            end
            StMemWait: begin
                o_pc_hold = 1'b1;
                o_fx_we   = 1'b0;
            end
            StFlush: begin
                o_flush = 1'b1;
                if (w_mem_stall) begin
                    o_pc_hold = 1'b1;
                    o_fx_we   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StRun;
            r_lu_block   <= 1'b0;
            r_pend_flush <= 1'b0;
            r_wait_cnt   <= 8'd0;
            r_flush_cnt  <= 3'd0;
            r_mem_err    <= 1'b0;
        end else begin
            // lu_block only ever lives for the cycle right after a load-use bubble.
            r_lu_block <= 1'b0;
            unique case (r_state)
                StRun: begin
                    r_wait_cnt <= 8'd0;
                    if (w_mem_stall) begin
                        r_state      <= StMemWait;
                        r_pend_flush <= w_branch;
                    end else if (w_load_use) begin
                        r_lu_block <= 1'b1;
                    end else if (w_branch && (FLUSH_CYCLES > 1)) begin
                        r_state     <= StFlush;
                        r_flush_cnt <= FLUSH_INIT;
                    end
                end
                StMemWait: begin
                    r_wait_cnt <= w_wait_inc;
                    if (w_timeout) begin
                        r_mem_err <= 1'b1;
                    end
                    // A timeout releases the pipeline exactly as a completed access would.
                    if (i_dmem_ready || w_timeout) begin
                        r_wait_cnt   <= 8'd0;
                        r_pend_flush <= 1'b0;
                        if (r_pend_flush) begin
                            r_state     <= StFlush;
                            r_flush_cnt <= 3'd1;
                        end else begin
                            r_state <= StRun;
                        end
                    end
                end
                StFlush: begin
                    if (!w_mem_stall) begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                        if (r_flush_cnt <= 3'd1) begin
                            r_state <= StRun;
                        end
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    // Clear has priority over counting; the counter sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (o_pc_hold && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Testbench for pipeline_stall_sequencer.
// Instance A uses default parameters; instance B uses FLUSH_CYCLES=3, MEM_TIMEOUT=3 and a
// 3-bit stall counter so timeout and saturation are reachable quickly. Both share inputs.
// Output vector order: {pc_hold, fx_we, x_noop, flush, fwd_a, fwd_b, mem_err}.
module tb_pipeline_stall_sequencer;

    localparam logic [6:0] OPC_NONE   = 7'b0000000;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode_x, opcode_w;
    logic [4:0] rd_w, rs1_x, rs2_x;
    logic       branch_taken, dmem_req, dmem_ready, cnt_clr;

    logic        a_pc_hold, a_fx_we, a_x_noop, a_flush, a_fwd_a, a_fwd_b, a_mem_err;
    logic [31:0] a_stall_cnt;
    logic        b_pc_hold, b_fx_we, b_x_noop, b_flush, b_fwd_a, b_fwd_b, b_mem_err;
    logic [2:0]  b_stall_cnt;

    always #5 clk = ~clk;

    pipeline_stall_sequencer u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_opcode_x(opcode_x), .i_opcode_w(opcode_w),
        .i_rd_w(rd_w), .i_rs1_x(rs1_x), .i_rs2_x(rs2_x), .i_branch_taken(branch_taken),
        .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready), .i_cnt_clr(cnt_clr),
        .o_pc_hold(a_pc_hold), .o_fx_we(a_fx_we), .o_x_noop(a_x_noop), .o_flush(a_flush),
        .o_fwd_a(a_fwd_a), .o_fwd_b(a_fwd_b), .o_mem_err(a_mem_err), .o_stall_cnt(a_stall_cnt)
    );

    pipeline_stall_sequencer #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_opcode_x(opcode_x), .i_opcode_w(opcode_w),
        .i_rd_w(rd_w), .i_rs1_x(rs1_x), .i_rs2_x(rs2_x), .i_branch_taken(branch_taken),
        .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready), .i_cnt_clr(cnt_clr),
        .o_pc_hold(b_pc_hold), .o_fx_we(b_fx_we), .o_x_noop(b_x_noop), .o_flush(b_flush),
        .o_fwd_a(b_fwd_a), .o_fwd_b(b_fwd_b), .o_mem_err(b_mem_err), .o_stall_cnt(b_stall_cnt)
    );

    // Scoreboard: expected {outputs, stall_cnt} pushed as stimulus is applied,
    // observed values pushed at the following negedge, compared at the end of each test.
    string       nm_q[$];
    logic [38:0] exp_q[$];
    logic [38:0] got_q[$];
    logic [31:0] model_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic set_in(input logic [6:0] ox, input logic [6:0] ow, input logic [4:0] rd,
                          input logic [4:0] r1, input logic [4:0] r2, input logic bt,
                          input logic req, input logic rdy);
        opcode_x = ox; opcode_w = ow; rd_w = rd; rs1_x = r1; rs2_x = r2;
        branch_taken = bt; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        set_in(OPC_NONE, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 32'd0;
    endtask

    // One cycle: record expectation, step the stall-count model, capture the chosen DUT.
    task automatic tick(input bit sel, input string nm, input logic [6:0] eo, input bit clr);
        logic [31:0] cmax;
        cmax = sel ? 32'd7 : 32'hFFFF_FFFF;
        nm_q.push_back(nm);
        exp_q.push_back({eo, model_cnt});
        if (clr) model_cnt = 32'd0;
        else if (eo[6] && model_cnt != cmax) model_cnt = model_cnt + 32'd1;
        @(negedge clk);
        if (sel)
            got_q.push_back({b_pc_hold, b_fx_we, b_x_noop, b_flush, b_fwd_a, b_fwd_b, b_mem_err,
                             29'd0, b_stall_cnt});
        else
            got_q.push_back({a_pc_hold, a_fx_we, a_x_noop, a_flush, a_fwd_a, a_fwd_b, a_mem_err,
                             a_stall_cnt});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [38:0] e, g;
        string nm;
        idle();
        rst = 1'b1;
        model_cnt = 32'd0;
        @(posedge clk); #1;
        tick(1'b0, "reset_a", 7'b0100000, 1'b1);
        tick(1'b1, "reset_b", 7'b0100000, 1'b1);
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got o=%b cnt=%0d, expected o=%b cnt=%0d",
                         nm, g[38:32], g[31:0], e[38:32], e[31:0]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [38:0] e, g;
        string nm;
        do_reset();
        set_in(OPC_NONE, OPC_LOAD, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "lu_stall", 7'b1010000, 1'b0);
        tick(1'b0, "lu_block", 7'b0100000, 1'b0);
        tick(1'b0, "lu_rearm", 7'b1010000, 1'b0);
        idle();
        tick(1'b0, "lu_idle", 7'b0100000, 1'b0);
        set_in(OPC_NONE, OPC_LOAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "lu_rd0", 7'b0100000, 1'b0);
        set_in(OPC_NONE, OPC_LOAD, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "lu_rs2", 7'b1010000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got o=%b cnt=%0d, expected o=%b cnt=%0d",
                         nm, g[38:32], g[31:0], e[38:32], e[31:0]);
            end
        end
    endtask

    task automatic test_forward();
        logic [38:0] e, g;
        string nm;
        do_reset();
        set_in(OPC_NONE, OPC_RTYPE, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "fwd_rtype_ab", 7'b0100110, 1'b0);
        set_in(OPC_NONE, OPC_RTYPE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "fwd_rd0", 7'b0100000, 1'b0);
        set_in(OPC_NONE, OPC_ITYPE, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "fwd_itype_a", 7'b0100100, 1'b0);
        set_in(OPC_NONE, OPC_JAL, 5'd4, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "fwd_jal_b", 7'b0100010, 1'b0);
        set_in(OPC_NONE, OPC_STORE, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "fwd_store_none", 7'b0100000, 1'b0);
        set_in(OPC_NONE, OPC_LUI, 5'd2, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "fwd_lui_ab", 7'b0100110, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got o=%b cnt=%0d, expected o=%b cnt=%0d",
                         nm, g[38:32], g[31:0], e[38:32], e[31:0]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [38:0] e, g;
        string nm;
        do_reset();
        set_in(OPC_NONE, OPC_RTYPE, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, "mw_enter", 7'b1000100, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, "mw_wait", 7'b1000000, 1'b0);
        dmem_ready = 1'b1;
        tick(1'b0, "mw_ready", 7'b1000000, 1'b0);
        set_in(OPC_NONE, OPC_RTYPE, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, "mw_back_run", 7'b0100100, 1'b0);
        idle();
        cnt_clr = 1'b1;
        tick(1'b0, "cnt_clr", 7'b0100000, 1'b1);
        cnt_clr = 1'b0;
        tick(1'b0, "cnt_cleared", 7'b0100000, 1'b0);
        set_in(OPC_NONE, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cnt_clr = 1'b1;
        tick(1'b0, "clr_wins", 7'b1000000, 1'b1);
        cnt_clr = 1'b0;
        dmem_ready = 1'b1;
        tick(1'b0, "clr_exit", 7'b1000000, 1'b0);
        idle();
        tick(1'b0, "clr_after", 7'b0100000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got o=%b cnt=%0d, expected o=%b cnt=%0d",
                         nm, g[38:32], g[31:0], e[38:32], e[31:0]);
            end
        end
    endtask

    task automatic test_branch();
        logic [38:0] e, g;
        string nm;
        do_reset();
        set_in(OPC_BRANCH, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, "br_flush", 7'b0101000, 1'b0);
        idle();
        tick(1'b0, "br_single", 7'b0100000, 1'b0);
        set_in(OPC_BRANCH, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, "br_wait_enter", 7'b1000000, 1'b0);
        set_in(OPC_NONE, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, "br_wait", 7'b1000000, 1'b0);
        dmem_ready = 1'b1;
        tick(1'b0, "br_ready", 7'b1000000, 1'b0);
        idle();
        tick(1'b0, "br_pend_flush", 7'b0101000, 1'b0);
        tick(1'b0, "br_pend_done", 7'b0100000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got o=%b cnt=%0d, expected o=%b cnt=%0d",
                         nm, g[38:32], g[31:0], e[38:32], e[31:0]);
            end
        end
    endtask

    // Instance B: timeout after 3 wait cycles, sticky error, 3-bit counter saturation.
    task automatic test_timeout();
        logic [38:0] e, g;
        string nm;
        do_reset();
        set_in(OPC_NONE, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++)
            tick(1'b1, $sformatf("to_wait%0d", i), (i <= 4) ? 7'b1000000 : 7'b1000001, 1'b0);
        set_in(OPC_NONE, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, "to_exit", 7'b1000001, 1'b0);
        idle();
        tick(1'b1, "to_sticky", 7'b0100001, 1'b0);
        rst = 1'b1;
        tick(1'b1, "to_in_rst", 7'b0100001, 1'b1);
        rst = 1'b0;
        tick(1'b1, "to_cleared", 7'b0100000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got o=%b cnt=%0d, expected o=%b cnt=%0d",
                         nm, g[38:32], g[31:0], e[38:32], e[31:0]);
            end
        end
    endtask

    // Instance B: load-use beats branch, 3-cycle flush, stall inside FLUSH, reset in FLUSH.
    task automatic test_priority_reset();
        logic [38:0] e, g;
        string nm;
        do_reset();
        set_in(OPC_BRANCH, OPC_LOAD, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, "pri_lu_over_br", 7'b1010000, 1'b0);
        tick(1'b1, "pri_br_rerun", 7'b0101000, 1'b0);
        idle();
        tick(1'b1, "fl_hold1", 7'b0101000, 1'b0);
        tick(1'b1, "fl_hold2", 7'b0101000, 1'b0);
        tick(1'b1, "fl_done", 7'b0100000, 1'b0);
        set_in(OPC_BRANCH, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, "fl_enter", 7'b0101000, 1'b0);
        set_in(OPC_NONE, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, "fl_memstall", 7'b1001000, 1'b0);
        idle();
        tick(1'b1, "fl_resume1", 7'b0101000, 1'b0);
        tick(1'b1, "fl_resume2", 7'b0101000, 1'b0);
        tick(1'b1, "fl_exit", 7'b0100000, 1'b0);
        set_in(OPC_BRANCH, OPC_NONE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, "fl_enter2", 7'b0101000, 1'b0);
        idle();
        rst = 1'b1;
        tick(1'b1, "fl_in_rst", 7'b0101000, 1'b1);
        rst = 1'b0;
        tick(1'b1, "fl_after_rst", 7'b0100000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got o=%b cnt=%0d, expected o=%b cnt=%0d",
                         nm, g[38:32], g[31:0], e[38:32], e[31:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_cnt = 32'd0;
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_branch();
        test_timeout();
        test_priority_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
